// File: rtl/bn_pkg.sv
// Shared definitions for the registered 1-to-N demultiplexer family.
package bn_pkg;

   function automatic int bn_lanes(int sel_w);
      return 1 << sel_w;
   endfunction

endpackage

// File: rtl/bn_lane_reg.sv
// One output lane: holding register, sticky valid flag and one-cycle write strobe.
module bn_lane_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  wr_en,
   input  logic                  ack,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   output logic                  strobe
);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  strobe_q, strobe_d;

   // A write beats a same-cycle ack; flush drops the flags but keeps the data.
   always_comb begin
      data_d   = data_q;
      valid_d  = valid_q && !ack;
      strobe_d = 1'b0;
      if (flush) begin
         valid_d = 1'b0;
      end else if (wr_en) begin
         data_d   = wr_data;
         valid_d  = 1'b1;
         strobe_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         valid_q  <= valid_d;
         strobe_q <= strobe_d;
      end
   end

   assign data   = data_q;
   assign valid  = valid_q;
   assign strobe = strobe_q;

endmodule

// File: rtl/bn_demux_1_n_reg.sv
// Registered 1-to-N demultiplexer: routes each accepted word to an explicit lane
// or to the lane under an auto-increment pointer.
module bn_demux_1_n_reg
   import bn_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 2
) (
   input  logic                                        Clk,
   input  logic                                        Rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [DATA_WIDTH-1:0]                       in_data,
   input  logic [SEL_WIDTH-1:0]                        in_sel,
   input  logic                                        in_auto,
   input  logic                                        flush,
   input  logic [bn_lanes(SEL_WIDTH)-1:0]              lane_ack,
   output logic [bn_lanes(SEL_WIDTH)*DATA_WIDTH-1:0]   y,
   output logic [bn_lanes(SEL_WIDTH)-1:0]              y_valid,
   output logic [bn_lanes(SEL_WIDTH)-1:0]              y_strobe,
   output logic [SEL_WIDTH-1:0]                        ptr
);

   localparam int N = bn_lanes(SEL_WIDTH);

   typedef logic [SEL_WIDTH-1:0] bn_sel_t;

   bn_sel_t ptr_q, ptr_d;
   bn_sel_t tgt;
   logic    accept;

   // Handshake: a word transfers on a rising edge where in_valid && in_ready;
   // in_ready never looks at in_valid, and a same-cycle ack frees the target lane.
   always_comb begin
      tgt      = in_auto ? ptr_q : in_sel;
      in_ready = !flush && (!y_valid[tgt] || lane_ack[tgt]);
      accept   = in_valid && in_ready;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (flush) begin
         ptr_d = '0;
      end else if (accept && in_auto) begin
         ptr_d = ptr_q + bn_sel_t'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic lane_wr;
      assign lane_wr = accept && (tgt == bn_sel_t'(i));

      bn_lane_reg #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
         .Clk    (Clk),
         .Rst    (Rst),
         .wr_en  (lane_wr),
         .ack    (lane_ack[i]),
         .flush  (flush),
         .wr_data(in_data),
         .data   (y[i*DATA_WIDTH +: DATA_WIDTH]),
         .valid  (y_valid[i]),
         .strobe (y_strobe[i])
      );
   end

endmodule

// File: doc/bn_demux_1_n_reg.md
# bn_demux_1_n_reg

Registered 1-to-N demultiplexer, the write-side counterpart of `bn_mux_n_1_generate`. It accepts one data word per handshake and routes it to one of 2**SEL_WIDTH output lanes. Each lane has a holding register with its own valid flag, and consumers release lanes with an acknowledge. The lane is selected either explicitly or by an internal auto-increment pointer for sequential fill, such as loading register banks or I/O latches.

## Interface
- DATA_WIDTH, 8, width of one data word / one lane
- SEL_WIDTH, 2, lane index width; N = 2**SEL_WIDTH lanes
- Clk  in  1  single clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept to the current target lane
- in_data  in  DATA_WIDTH  word to route
- in_sel  in  SEL_WIDTH  explicit target lane, used when in_auto=0
- in_auto  in  1  1: target = internal pointer; 0: target = in_sel
- flush  in  1  clears all lane valid flags and the pointer
- lane_ack  in  N  per-lane consumer release, bit i clears lane i
- y  out  N*DATA_WIDTH  lane registers, lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- y_valid  out  N  sticky per-lane valid
- y_strobe  out  N  one-cycle pulse on the cycle after lane i is written
- ptr  out  SEL_WIDTH  current auto-increment pointer

## Operation
- Target index: `tgt = in_auto ? ptr : in_sel`.
- in_ready is combinational: `in_ready = !flush && (!y_valid[tgt] || lane_ack[tgt])`. It depends on in_auto, in_sel, lane_ack and state. It does not depend on in_valid.
- Accept: when `in_valid && in_ready` at a rising edge, the block does the following:
  - Loads lane `tgt` with in_data.
  - Sets y_valid[tgt]=1 and y_strobe[tgt]=1.
  - If in_auto=1, sets ptr to ptr+1, wrapping from N-1 to 0.
- Explicit-mode accepts never move ptr.
- Ack: lane_ack[i] clears y_valid[i] at the edge. Acking a lane that is not valid has no effect. y data is not cleared by ack; it holds its last value.
- Simultaneous ack and write to the same lane: the write wins. y_valid stays 1, y updates and y_strobe pulses.
- Simultaneous writes to one lane and acks to other lanes: all take effect independently.
- flush has priority over everything except Rst:
  - y_valid goes to all 0, ptr to 0, y_strobe to 0.
  - y data is retained.
  - No accept happens in a flush cycle.
- Stall: if target lane i is valid and not acked, the producer waits. Auto mode stalls at ptr=i; it never skips ahead.
- Rst clears y, y_valid, y_strobe and ptr to 0. Because in_ready depends on y_valid, in_ready=1 in the first cycle after reset unless flush is high.
- Rst asserted mid-stream discards all held lanes. An accept presented in the Rst cycle is dropped.

## Timing
- Latency is 1 cycle: the word accepted at edge k is visible on y and y_valid after edge k.
- y_strobe is high for exactly the cycle after the accepting edge, then returns to 0. It repeats each cycle on back-to-back writes.
- Throughput is 1 word/cycle when target lanes are free or being acked the same cycle.
- Ack-to-ready: a same-cycle ack makes the lane writable in that cycle (combinational path lane_ack→in_ready).
- ptr wraps modulo N after N auto accepts, with no terminal flag.

## Structure
- Shared package `bn_pkg`:
  - `function automatic int bn_lanes(int sel_w)` returning 2**sel_w.
  - Typedef for the lane index, `bn_sel_t` parameterised via module localparam.
- Sub-module `bn_lane_reg` is instantiated N times in a generate loop. It holds the data register, valid, and strobe, with inputs wr_en, ack, flush and Rst.
- The top level holds ptr, target selection, in_ready and the flattening of lanes into y.

## Test plan
- Reset: hold Rst 2 cycles with in_valid=1 → y=0, y_valid=0000, y_strobe=0000, ptr=0, and no lane loaded. After release, in_ready=1.
- Auto fill: in_auto=1, send 0x11, 0x22, 0x33, 0x44 back-to-back → y = 0x44332211, y_valid=1111, ptr wraps to 0. y_strobe pulses 0001, 0010, 0100, 1000 on consecutive cycles.
- Stall/ack: from the full state, send 0x55 in auto mode → in_ready=0 until lane_ack=0001. In that same cycle the accept happens and lane0=0x55, with y_valid remaining 1111.
- Explicit select: in_auto=0, in_sel=2, data 0xA5 after reset → only lane 2 is loaded, y_valid=0100, ptr stays 0.
- Same-lane ack+write: lane 1 valid, in_sel=1, lane_ack=0010, data 0x3C → y_valid[1]=1, lane1=0x3C, y_strobe[1] pulses.
- Flush: lanes 0-2 valid, ptr=3, flush with in_valid=1 → y_valid=0000, ptr=0, data retained, no accept that cycle.
